// File: rtl/morse_quiz_ctrl_pkg.sv
// Shared definitions for the Morse quiz controller: symbol codes, FSM states
// and the letter-selection helper.
package morse_quiz_ctrl_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;

  localparam int unsigned LETTER_COUNT = 26;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PICK     = 3'd1,
    ST_WAIT     = 3'd2,
    ST_CHECK    = 3'd3,
    ST_FEEDBACK = 3'd4,
    ST_FINISH   = 3'd5
  } state_e;

  // Reduce the LFSR value to a letter and step past a repeat of the previous one.
  function automatic logic [4:0] pick_letter(input logic [4:0] rnd, input logic [4:0] prev);
    logic [4:0] v;
    v = (rnd >= 5'(LETTER_COUNT)) ? (rnd - 5'(LETTER_COUNT)) : rnd;
    if (v == prev) begin
      v = (v == 5'(LETTER_COUNT - 1)) ? 5'd0 : (v + 5'd1);
    end else begin
      v = v;
    end
    return v;
  endfunction

endpackage

// File: rtl/morse_letter_rom.sv
// Combinational A..Z Morse code table; first symbol on sym_one, unused slots 00.
module morse_letter_rom
  import morse_quiz_ctrl_pkg::*;
(
  input  logic [4:0] index,
  output logic [1:0] sym_one,
  output logic [1:0] sym_two,
  output logic [1:0] sym_three,
  output logic [1:0] sym_four,
  output logic [1:0] sym_five
);

  localparam logic [1:0] DT = SYM_DOT;
  localparam logic [1:0] DA = SYM_DASH;
  localparam logic [1:0] NO = SYM_NONE;

  logic [9:0] code_s;

  // Letter index to left-aligned symbol sequence.
  always_comb begin
    code_s = {NO, NO, NO, NO, NO};
    case (index)
      5'd0:    code_s = {DT, DA, NO, NO, NO};
      5'd1:    code_s = {DA, DT, DT, DT, NO};
      5'd2:    code_s = {DA, DT, DA, DT, NO};
      5'd3:    code_s = {DA, DT, DT, NO, NO};
      5'd4:    code_s = {DT, NO, NO, NO, NO};
      5'd5:    code_s = {DT, DT, DA, DT, NO};
      5'd6:    code_s = {DA, DA, DT, NO, NO};
      5'd7:    code_s = {DT, DT, DT, DT, NO};
      5'd8:    code_s = {DT, DT, NO, NO, NO};
      5'd9:    code_s = {DT, DA, DA, DA, NO};
      5'd10:   code_s = {DA, DT, DA, NO, NO};
      5'd11:   code_s = {DT, DA, DT, DT, NO};
      5'd12:   code_s = {DA, DA, NO, NO, NO};
      5'd13:   code_s = {DA, DT, NO, NO, NO};
      5'd14:   code_s = {DA, DA, DA, NO, NO};
      5'd15:   code_s = {DT, DA, DA, DT, NO};
      5'd16:   code_s = {DA, DA, DT, DA, NO};
      5'd17:   code_s = {DT, DA, DT, NO, NO};
      5'd18:   code_s = {DT, DT, DT, NO, NO};
      5'd19:   code_s = {DA, NO, NO, NO, NO};
      5'd20:   code_s = {DT, DT, DA, NO, NO};
      5'd21:   code_s = {DT, DT, DT, DA, NO};
      5'd22:   code_s = {DT, DA, DA, NO, NO};
      5'd23:   code_s = {DA, DT, DT, DA, NO};
      5'd24:   code_s = {DA, DT, DA, DA, NO};
      5'd25:   code_s = {DA, DA, DT, DT, NO};
      default: code_s = {NO, NO, NO, NO, NO};
    endcase
  end

  assign sym_one   = code_s[9:8];
  assign sym_two   = code_s[7:6];
  assign sym_three = code_s[5:4];
  assign sym_four  = code_s[3:2];
  assign sym_five  = code_s[1:0];

endmodule

// File: rtl/morse_quiz_ctrl.sv
// Morse quiz session controller: picks pseudo-random letters, times the answer,
// grades the captured symbols against the code table and keeps score.
module morse_quiz_ctrl
  import morse_quiz_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS          = 10,
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter int unsigned FEEDBACK_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       letter_done,
  input  logic [1:0] morse_one,
  input  logic [1:0] morse_two,
  input  logic [1:0] morse_three,
  input  logic [1:0] morse_four,
  input  logic [1:0] morse_five,
  output logic [4:0] target_letter,
  output logic       busy,
  output logic       correct,
  output logic       wrong,
  output logic [3:0] score,
  output logic [3:0] round,
  output logic       quiz_done
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned FW = $clog2(FEEDBACK_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FB_LAST  = FW'(FEEDBACK_CYCLES - 1);
  localparam logic [4:0]    ROUNDS_L = 5'(ROUNDS);

  state_e        state_q, state_d;
  logic [4:0]    lfsr_q, lfsr_d;
  logic          ld_q, ld_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [FW-1:0] fb_q, fb_d;
  logic [9:0]    sym_q, sym_d;
  logic [4:0]    target_q, target_d;
  logic [3:0]    score_q, score_d;
  logic [3:0]    round_q, round_d;
  logic          correct_q, correct_d;
  logic          wrong_q, wrong_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [1:0] rom_one_s, rom_two_s, rom_three_s, rom_four_s, rom_five_s;
  logic [9:0] rom_code_s;
  logic       press_s;
  logic [3:0] score_inc_s;
  logic [3:0] round_inc_s;

  morse_letter_rom u_rom (
    .index     (target_q),
    .sym_one   (rom_one_s),
    .sym_two   (rom_two_s),
    .sym_three (rom_three_s),
    .sym_four  (rom_four_s),
    .sym_five  (rom_five_s)
  );

  assign rom_code_s  = {rom_one_s, rom_two_s, rom_three_s, rom_four_s, rom_five_s};
  assign press_s     = letter_done & ~ld_q;
  assign score_inc_s = (score_q == 4'd15) ? score_q : (score_q + 4'd1);
  assign round_inc_s = (round_q == 4'd15) ? round_q : (round_q + 4'd1);

  // Next-state and next-output logic for the whole quiz.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    ld_d      = letter_done;
    tmo_d     = '0;
    fb_d      = '0;
    sym_d     = sym_q;
    target_d  = target_q;
    score_d   = score_q;
    round_d   = round_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (start) begin
          state_d = ST_PICK;
          score_d = 4'd0;
          round_d = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_PICK: begin
        target_d = pick_letter(lfsr_q, target_q);
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // A fresh press beats a timeout landing on the same cycle.
        if (press_s) begin
          sym_d   = {morse_one, morse_two, morse_three, morse_four, morse_five};
          state_d = ST_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          wrong_d = 1'b1;
          state_d = ST_FEEDBACK;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_CHECK: begin
        if (sym_q == rom_code_s) begin
          correct_d = 1'b1;
          score_d   = score_inc_s;
        end else begin
          wrong_d = 1'b1;
        end
        state_d = ST_FEEDBACK;
      end
      ST_FEEDBACK: begin
        if (fb_q == FB_LAST) begin
          round_d = round_inc_s;
          state_d = ({1'b0, round_inc_s} >= ROUNDS_L) ? ST_FINISH : ST_PICK;
        end else begin
          fb_d = fb_q + FW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    done_d = (state_d == ST_FINISH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= 5'b00001;
      ld_q      <= 1'b0;
      tmo_q     <= '0;
      fb_q      <= '0;
      sym_q     <= 10'd0;
      target_q  <= 5'd0;
      score_q   <= 4'd0;
      round_q   <= 4'd0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      ld_q      <= ld_d;
      tmo_q     <= tmo_d;
      fb_q      <= fb_d;
      sym_q     <= sym_d;
      target_q  <= target_d;
      score_q   <= score_d;
      round_q   <= round_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign target_letter = target_q;
  assign busy          = busy_q;
  assign correct       = correct_q;
  assign wrong         = wrong_q;
  assign score         = score_q;
  assign round         = round_q;
  assign quiz_done     = done_q;

endmodule

// File: tb/tb_morse_quiz_ctrl.sv
// Randomized self-checking bench for morse_quiz_ctrl with a small session model.
module tb_morse_quiz_ctrl;

  localparam int NROUNDS = 3;
  localparam int NTMO    = 8;
  localparam int NFB     = 4;

  logic       clock, reset, start, letter_done;
  logic [1:0] morse_one, morse_two, morse_three, morse_four, morse_five;
  logic [4:0] target_letter;
  logic       busy, correct, wrong, quiz_done;
  logic [3:0] score, round;

  morse_quiz_ctrl #(
    .ROUNDS          (NROUNDS),
    .TIMEOUT_CYCLES  (NTMO),
    .FEEDBACK_CYCLES (NFB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .letter_done   (letter_done),
    .morse_one     (morse_one),
    .morse_two     (morse_two),
    .morse_three   (morse_three),
    .morse_four    (morse_four),
    .morse_five    (morse_five),
    .target_letter (target_letter),
    .busy          (busy),
    .correct       (correct),
    .wrong         (wrong),
    .score         (score),
    .round         (round),
    .quiz_done     (quiz_done)
  );

  always #5 clock = ~clock;

  string morse_tab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                            "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                            "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                            "-.--", "--.."};

  int checks, errors;
  int exp_target, exp_score, exp_round;
  int cyc;
  logic [4:0] seq [31];

  // Clock edges since the last reset; the LFSR value is a function of this.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [9:0] encode(input string s);
    logic [9:0] c;
    byte b;
    c = 10'd0;
    for (int i = 0; i < 5; i++) begin
      if (i < s.len()) begin
        b = s[i];
        c[9-2*i -: 2] = (b == 8'h2E) ? 2'b01 : 2'b10;
      end
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_syms(input logic [9:0] c);
    {morse_one, morse_two, morse_three, morse_four, morse_five} = c;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; letter_done = 1'b0; set_syms(10'd0);
    repeat (2) tick();
    reset = 1'b0;
    exp_target = 0; exp_score = 0; exp_round = 0;
  endtask

  // Step through PICK and check the letter chosen from the LFSR sequence.
  task automatic do_pick();
    int v;
    tick();
    v = seq[(cyc - 1) % 31] % 26;
    if (v == exp_target) v = (v + 1) % 26;
    exp_target = v;
    checks++;
    if (target_letter !== 5'(v)) begin
      errors++; $display("FAIL pick_target got %0d exp %0d", target_letter, v);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL pick_busy got %0b exp 1", busy);
    end
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({score, round, busy, quiz_done} !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL start_clear got score %0d round %0d busy %0b done %0b exp 0 0 1 0",
                         score, round, busy, quiz_done);
    end
    exp_score = 0; exp_round = 0;
    do_pick();
  endtask

  // mode 0 correct, 1 other letter, 2 illegal symbol, 3 timeout.
  task automatic run_round(input int mode);
    logic [9:0] code;
    logic [1:0] exp_pulse;
    int d;
    code = encode(morse_tab[exp_target]);
    if (mode == 1) begin
      code = encode(morse_tab[(exp_target + 1 + $urandom_range(0, 24)) % 26]);
    end else if (mode == 2) begin
      d = $urandom_range(0, 4);
      code[9-2*d -: 2] = 2'b11;
    end
    if (mode != 3) begin
      d = $urandom_range(0, 5);
      for (int i = 0; i < d; i++) begin
        start = 1'($urandom_range(0, 1));
        tick();
        checks++;
        if ({correct, wrong} !== 2'b00) begin
          errors++; $display("FAIL wait_quiet got %b exp 00", {correct, wrong});
        end
      end
      start = 1'b0; set_syms(code); letter_done = 1'b1;
      tick();
      checks++;
      if ({correct, wrong} !== 2'b00) begin
        errors++; $display("FAIL check_quiet got %b exp 00", {correct, wrong});
      end
      tick();
      if (mode == 0) exp_score = (exp_score < 15) ? exp_score + 1 : 15;
      exp_pulse = (mode == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({correct, wrong} !== exp_pulse) begin
        errors++; $display("FAIL grade mode %0d got %b exp %b", mode, {correct, wrong}, exp_pulse);
      end
    end else begin
      for (int k = 0; k < NTMO; k++) begin
        start = (k < NTMO - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        exp_pulse = (k == NTMO - 1) ? 2'b01 : 2'b00;
        checks++;
        if ({correct, wrong} !== exp_pulse) begin
          errors++; $display("FAIL timeout k %0d got %b exp %b", k, {correct, wrong}, exp_pulse);
        end
      end
    end
    start = 1'b0; letter_done = 1'b0; set_syms(10'($urandom));
    tick();
    checks++;
    if ({correct, wrong} !== 2'b00) begin
      errors++; $display("FAIL pulse_width got %b exp 00", {correct, wrong});
    end
    repeat (NFB - 2) tick();
    checks++;
    if (round !== 4'(exp_round)) begin
      errors++; $display("FAIL round_hold got %0d exp %0d", round, exp_round);
    end
    tick();
    exp_round++;
    checks++;
    if ({round, score} !== {4'(exp_round), 4'(exp_score)}) begin
      errors++; $display("FAIL round_end got round %0d score %0d exp %0d %0d",
                         round, score, exp_round, exp_score);
    end
    if (exp_round >= NROUNDS) begin
      checks++;
      if ({quiz_done, busy} !== 2'b10) begin
        errors++; $display("FAIL finish_flags got %b exp 10", {quiz_done, busy});
      end
    end else begin
      checks++;
      if ({quiz_done, busy} !== 2'b01) begin
        errors++; $display("FAIL next_flags got %b exp 01", {quiz_done, busy});
      end
      do_pick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({target_letter, score, round, correct, wrong, busy, quiz_done} !== 17'd0) begin
      errors++; $display("FAIL reset_state got %0d %0d %0d %b%b%b%b exp all 0",
                         target_letter, score, round, correct, wrong, busy, quiz_done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, quiz_done} !== 2'b00) begin
      errors++; $display("FAIL idle_hold got %b exp 00", {busy, quiz_done});
    end
    exp_target = 0; exp_score = 0; exp_round = 0;
  endtask

  task automatic test_all_correct();
    do_reset();
    repeat ($urandom_range(0, 30)) tick();
    start_session();
    for (int r = 0; r < NROUNDS; r++) run_round(0);
    repeat (3) tick();
    checks++;
    if ({quiz_done, score, round} !== {1'b1, 4'd3, 4'd3}) begin
      errors++; $display("FAIL finish_hold got done %0b score %0d round %0d exp 1 3 3",
                         quiz_done, score, round);
    end
    start_session();
  endtask

  task automatic test_mixed_sessions();
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < NROUNDS; r++) run_round($urandom_range(0, 3));
      checks++;
      if (score !== 4'(exp_score)) begin
        errors++; $display("FAIL session_score got %0d exp %0d", score, exp_score);
      end
      repeat ($urandom_range(0, 5)) tick();
      start_session();
    end
  endtask

  task automatic test_timeouts();
    for (int r = 0; r < NROUNDS; r++) run_round(3);
    checks++;
    if ({score, round} !== {4'd0, 4'd3}) begin
      errors++; $display("FAIL timeout_session got score %0d round %0d exp 0 3", score, round);
    end
  endtask

  task automatic test_held_letter_done();
    do_reset();
    letter_done = 1'b1;
    set_syms(10'd0);
    repeat (2) tick();
    start_session();
    repeat (3) begin
      tick();
      checks++;
      if ({correct, wrong, busy} !== 3'b001) begin
        errors++; $display("FAIL held_ignored got %b exp 001", {correct, wrong, busy});
      end
    end
    letter_done = 1'b0;
    set_syms(encode(morse_tab[exp_target]));
    tick();
    letter_done = 1'b1;
    tick();
    tick();
    checks++;
    if ({correct, wrong, score} !== {2'b10, 4'd1}) begin
      errors++; $display("FAIL held_repress got %b score %0d exp 10 1", {correct, wrong}, score);
    end
    letter_done = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    start_session();
    run_round(0);
    repeat (2) tick();
    set_syms(encode(morse_tab[exp_target]));
    letter_done = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_target = 0; exp_score = 0; exp_round = 0;
    checks++;
    if ({busy, score, round, target_letter, correct, wrong, quiz_done} !== 17'd0) begin
      errors++; $display("FAIL reset_mid_wait got busy %0b score %0d round %0d tgt %0d pulses %b%b done %0b",
                         busy, score, round, target_letter, correct, wrong, quiz_done);
    end
    repeat (3) begin
      tick();
      checks++;
      if ({correct, wrong, busy} !== 3'b000) begin
        errors++; $display("FAIL post_reset_quiet got %b exp 000", {correct, wrong, busy});
      end
    end
    letter_done = 1'b0;
  endtask

  initial begin
    logic [4:0] s;
    clock = 1'b0; reset = 1'b1; start = 1'b0; letter_done = 1'b0;
    set_syms(10'd0);
    checks = 0; errors = 0;
    s = 5'd1;
    for (int i = 0; i < 31; i++) begin
      seq[i] = s;
      s = {s[3:0], s[4] ^ s[2]};
    end
    test_reset();
    test_all_correct();
    test_mixed_sessions();
    test_timeouts();
    test_held_letter_done();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
